// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory stage of the pipeline. It consumes the M-stage control, address and
// store data, runs the load or store over a byte-wide req/ack memory port,
// and loads the W-stage pipeline register.
//
// A 19-bit word access is split into three byte transfers at addresses
// ALUResultM, +1 and +2 (wrapping modulo 2^19). A single-byte access uses one
// transfer. StallM holds the upstream pipeline while an access is pending or
// in flight. Upstream keeps every M input stable while StallM is high, so the
// M inputs are read directly throughout the access.
//
// Handshake: a byte transfer completes on a rising edge where mem_req and
// mem_ack are both high. mem_req stays high from the first byte to the last,
// so back-to-back acks move one byte per cycle. mem_we, mem_addr and mem_wdata
// are stable while mem_req is high and the transfer is waiting for its ack.
// An ack that arrives while mem_req is low is ignored.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   RegWriteM, MemWriteM,
//   ResultSrcM, RDM,
//   WriteDataM, ALUResultM,
//   Cant_ByteM            M-stage inputs (Cant_ByteM=1 selects a byte access)
//   StallM                holds upstream; combinational
//   mem_req, mem_we,
//   mem_addr, mem_wdata   byte memory request side
//   mem_rdata, mem_ack    byte memory response side
//   RegWriteW, ResultSrcW,
//   RDW, ALUResultW,
//   ReadDataW             W-stage pipeline register
//   mem_err               sticky ack-timeout flag; cleared only by reset
//   state_dbg_o           current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int DATA_W         = 19,  // fixed at 19; byte lanes assume it
  parameter int TIMEOUT_CYCLES = 64   // 0 disables the ack timeout
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic [4:0]        RDM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic              Cant_ByteM,
  output logic              StallM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [4:0]        RDW,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic              mem_err,
  output logic [1:0]        state_dbg_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  // The wait counter only needs to reach TIMEOUT_CYCLES-1: the cycle that
  // would take it to TIMEOUT_CYCLES is the cycle that fires the timeout.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0][7:0]    buf_q, buf_d;
  logic               err_q, err_d;

  logic               reg_write_w_q, reg_write_w_d;
  logic               result_src_w_q, result_src_w_d;
  logic [4:0]         rd_w_q, rd_w_d;
  logic [DATA_W-1:0]  alu_result_w_q, alu_result_w_d;
  logic [DATA_W-1:0]  read_data_w_q, read_data_w_d;

  // ---------------------------------------------------------------------------
  // Decode of the presented operation
  // ---------------------------------------------------------------------------
  logic mem_op;
  logic is_load;
  logic last_byte;
  logic timeout_hit;

  // A store wins when both MemWriteM and ResultSrcM are set.
  assign mem_op      = MemWriteM | ResultSrcM;
  assign is_load     = ResultSrcM & ~MemWriteM;
  assign last_byte   = Cant_ByteM ? (idx_q == 2'd0) : (idx_q == 2'd2);
  assign timeout_hit = TO_EN && !mem_ack && (cnt_q == TO_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      idx_q          <= 2'd0;
      cnt_q          <= '0;
      buf_q          <= '0;
      err_q          <= 1'b0;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= 1'b0;
      rd_w_q         <= 5'd0;
      alu_result_w_q <= '0;
      read_data_w_q  <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      buf_q          <= buf_d;
      err_q          <= err_d;
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      rd_w_q         <= rd_w_d;
      alu_result_w_q <= alu_result_w_d;
      read_data_w_q  <= read_data_w_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    buf_d          = buf_q;
    err_d          = err_q;
    // The W register takes a bubble unless a result retires this cycle.
    reg_write_w_d  = 1'b0;
    result_src_w_d = 1'b0;
    rd_w_d         = 5'd0;
    alu_result_w_d = '0;
    read_data_w_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          state_d = S_ACCESS;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else begin
          reg_write_w_d  = RegWriteM;
          result_src_w_d = ResultSrcM;
          rd_w_d         = RDM;
          alu_result_w_d = ALUResultM;
        end
      end

      S_ACCESS: begin
        if (mem_ack) begin
          if (is_load) begin
            buf_d[idx_q] = mem_rdata;
          end
          cnt_d = '0;
          if (last_byte) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else if (timeout_hit) begin
          // Bytes not yet received read back as zero.
          err_d = 1'b1;
          for (int i = 0; i < 3; i++) begin
            if (i >= int'(idx_q)) begin
              buf_d[i] = 8'h00;
            end
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        reg_write_w_d  = RegWriteM;
        result_src_w_d = ResultSrcM;
        rd_w_d         = RDM;
        alu_result_w_d = ALUResultM;
        if (is_load) begin
          if (Cant_ByteM) begin
            read_data_w_d = {11'b0, buf_q[0]};
          end else begin
            read_data_w_d = {buf_q[2][2:0], buf_q[1], buf_q[0]};
          end
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    // Reset drops the stall immediately so upstream is released in the same
    // cycle the in-flight access is abandoned.
    StallM    = 1'b0;

    if (!reset) begin
      StallM = ((state_q == S_IDLE) && mem_op) || (state_q == S_ACCESS);
    end

    if (state_q == S_ACCESS) begin
      mem_req  = 1'b1;
      mem_we   = MemWriteM;
      // Addition truncates to DATA_W bits, giving the modulo-2^19 wrap.
      mem_addr = ALUResultM + {{(DATA_W-2){1'b0}}, idx_q};
      unique case (idx_q)
        2'd0:    mem_wdata = WriteDataM[7:0];
        2'd1:    mem_wdata = WriteDataM[15:8];
        default: mem_wdata = {5'b0, WriteDataM[18:16]};
      endcase
    end
  end

  assign RegWriteW   = reg_write_w_q;
  assign ResultSrcW  = result_src_w_q;
  assign RDW         = rd_w_q;
  assign ALUResultW  = alu_result_w_q;
  assign ReadDataW   = read_data_w_q;
  assign mem_err     = err_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//
// Directed bench for mem_access_stage with TIMEOUT_CYCLES=4. Non-memory ops
// come from a vector table; the multi-cycle memory cases are hand-written
// sequences. Every completed memory transfer is checked against an expected
// queue of {we, addr, wdata} records.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT connections
  // ---------------------------------------------------------------------------
  logic        RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM;
  logic [4:0]  RDM;
  logic [18:0] WriteDataM, ALUResultM;
  logic        StallM, mem_req, mem_we, mem_ack;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        RegWriteW, ResultSrcW, mem_err;
  logic [4:0]  RDW;
  logic [18:0] ALUResultW, ReadDataW;
  logic [1:0]  state_dbg;

  mem_access_stage #(.DATA_W(19), .TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .RDM        (RDM),
    .WriteDataM (WriteDataM),
    .ALUResultM (ALUResultM),
    .Cant_ByteM (Cant_ByteM),
    .StallM     (StallM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .RDW        (RDW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .mem_err    (mem_err),
    .state_dbg_o(state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Memory contents seen by loads
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] mem_byte(input logic [18:0] a);
    case (a)
      19'h7FFFF: return 8'h11;
      19'h00000: return 8'h22;
      19'h00001: return 8'h33;
      default:   return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  assign mem_rdata = mem_byte(mem_addr);

  // ---------------------------------------------------------------------------
  // Counters and compare helper
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard of completed transfers: {we, addr, wdata}
  // ---------------------------------------------------------------------------
  logic [27:0] exp_q[$];

  always @(posedge clk) begin
    if (!reset && mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_xfer", {4'h0, mem_we, mem_addr, mem_wdata}, 32'h0);
      end else begin
        check("sb_xfer", {4'h0, mem_we, mem_addr, mem_wdata},
              {4'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    RegWriteM  = 1'b0;
    MemWriteM  = 1'b0;
    ResultSrcM = 1'b0;
    Cant_ByteM = 1'b0;
    RDM        = 5'd0;
    WriteDataM = 19'h0;
    ALUResultM = 19'h0;
    mem_ack    = 1'b0;
  endtask

  task automatic drive_op(input logic rw, input logic mw, input logic rs,
                          input logic cb, input logic [4:0] rd,
                          input logic [18:0] wd, input logic [18:0] alu);
    RegWriteM  = rw;
    MemWriteM  = mw;
    ResultSrcM = rs;
    Cant_ByteM = cb;
    RDM        = rd;
    WriteDataM = wd;
    ALUResultM = alu;
  endtask

  // ---------------------------------------------------------------------------
  // Non-memory vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        reg_write;
    logic [4:0]  rd;
    logic [18:0] alu;
    logic        exp_rw;
    logic [4:0]  exp_rd;
    logic [18:0] exp_alu;
  } vec_t;

  vec_t vecs[4];

  // ---------------------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------------------
  initial begin
    vecs[0] = '{1'b1, 5'd7,  19'h12345, 1'b1, 5'd7,  19'h12345};
    vecs[1] = '{1'b0, 5'd31, 19'h7FFFF, 1'b0, 5'd31, 19'h7FFFF};
    vecs[2] = '{1'b1, 5'd0,  19'h00000, 1'b1, 5'd0,  19'h00000};
    vecs[3] = '{1'b1, 5'd16, 19'h00001, 1'b1, 5'd16, 19'h00001};

    // Reset state
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    check("rst_state",   {30'h0, state_dbg}, 32'd0);
    check("rst_mem_req", {31'h0, mem_req},   32'd0);
    check("rst_stall",   {31'h0, StallM},    32'd0);
    check("rst_regw",    {31'h0, RegWriteW}, 32'd0);
    check("rst_alu_w",   {13'h0, ALUResultW}, 32'd0);
    check("rst_err",     {31'h0, mem_err},   32'd0);
    reset = 1'b0;

    // Non-memory ops: one-cycle latency, no stall
    for (int i = 0; i < 4; i++) begin
      drive_op(vecs[i].reg_write, 1'b0, 1'b0, 1'b0, vecs[i].rd, 19'h0,
               vecs[i].alu);
      #1;
      check("vec_stall", {31'h0, StallM}, 32'd0);
      step();
      check("vec_regw",  {31'h0, RegWriteW},  {31'h0, vecs[i].exp_rw});
      check("vec_rdw",   {27'h0, RDW},        {27'h0, vecs[i].exp_rd});
      check("vec_alu_w", {13'h0, ALUResultW}, {13'h0, vecs[i].exp_alu});
      check("vec_rd_data", {13'h0, ReadDataW}, 32'd0);
    end

    // Byte store, ack tied high
    idle_inputs();
    exp_q.push_back({1'b1, 19'h00010, 8'hCD});
    drive_op(1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 19'h7ABCD, 19'h00010);
    mem_ack = 1'b1;
    #1;
    check("bst_stall_idle", {31'h0, StallM}, 32'd1);
    step();
    check("bst_state_acc", {30'h0, state_dbg}, 32'd1);
    check("bst_stall_acc", {31'h0, StallM},    32'd1);
    check("bst_req",       {31'h0, mem_req},   32'd1);
    check("bst_we",        {31'h0, mem_we},    32'd1);
    check("bst_addr",      {13'h0, mem_addr},  32'h10);
    check("bst_wdata",     {24'h0, mem_wdata}, 32'hCD);
    step();
    check("bst_state_done", {30'h0, state_dbg}, 32'd2);
    check("bst_stall_done", {31'h0, StallM},    32'd0);
    check("bst_req_done",   {31'h0, mem_req},   32'd0);
    step();
    check("bst_regw",  {31'h0, RegWriteW},  32'd0);
    check("bst_rdw",   {27'h0, RDW},        32'd3);
    check("bst_alu_w", {13'h0, ALUResultW}, 32'h10);
    check("bst_rdata", {13'h0, ReadDataW},  32'd0);
    idle_inputs();

    // Word load across the top of the address space, ack tied high
    exp_q.push_back({1'b0, 19'h7FFFF, 8'h00});
    exp_q.push_back({1'b0, 19'h00000, 8'h00});
    exp_q.push_back({1'b0, 19'h00001, 8'h00});
    drive_op(1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 19'h0, 19'h7FFFF);
    mem_ack = 1'b1;
    step();
    check("wld_addr0", {13'h0, mem_addr}, 32'h7FFFF);
    step();
    check("wld_addr1_wrap", {13'h0, mem_addr}, 32'h00000);
    check("wld_req_held",   {31'h0, mem_req},  32'd1);
    step();
    check("wld_addr2", {13'h0, mem_addr}, 32'h00001);
    step();
    check("wld_state_done", {30'h0, state_dbg}, 32'd2);
    check("wld_stall_done", {31'h0, StallM},    32'd0);
    check("wld_rdw_early",  {27'h0, RDW},       32'd0);
    step();
    check("wld_rdata",  {13'h0, ReadDataW},  32'h32211);
    check("wld_rdw",    {27'h0, RDW},        32'd9);
    check("wld_regw",   {31'h0, RegWriteW},  32'd1);
    check("wld_rsrc",   {31'h0, ResultSrcW}, 32'd1);
    check("wld_alu_w",  {13'h0, ALUResultW}, 32'h7FFFF);
    idle_inputs();

    // Word store, ack held low 3 cycles per byte
    exp_q.push_back({1'b1, 19'h00100, 8'hCD});
    exp_q.push_back({1'b1, 19'h00101, 8'hAB});
    exp_q.push_back({1'b1, 19'h00102, 8'h07});
    drive_op(1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 19'h7ABCD, 19'h00100);
    #1;
    check("wst_stall_idle", {31'h0, StallM}, 32'd1);
    step();
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 3; k++) begin
        check("wst_req_wait",   {31'h0, mem_req}, 32'd1);
        check("wst_stall_wait", {31'h0, StallM},  32'd1);
        step();
      end
      mem_ack = 1'b1;
      check("wst_addr", {13'h0, mem_addr}, 32'h100 + 32'(b));
      step();
      mem_ack = 1'b0;
    end
    check("wst_state_done", {30'h0, state_dbg}, 32'd2);
    check("wst_stall_done", {31'h0, StallM},    32'd0);
    check("wst_no_err",     {31'h0, mem_err},   32'd0);
    step();
    check("wst_rdata", {13'h0, ReadDataW}, 32'd0);
    check("wst_rdw",   {27'h0, RDW},       32'd5);
    idle_inputs();

    // Byte load that never gets an ack: times out after 4 waiting cycles
    drive_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 19'h0, 19'h00200);
    step();
    step();
    step();
    step();
    check("to_state_waiting", {30'h0, state_dbg}, 32'd1);
    check("to_err_early",     {31'h0, mem_err},   32'd0);
    step();
    check("to_err_set",    {31'h0, mem_err},   32'd1);
    check("to_state_done", {30'h0, state_dbg}, 32'd2);
    check("to_stall_done", {31'h0, StallM},    32'd0);
    mem_ack = 1'b1;  // late ack in DONE must be ignored
    step();
    check("to_rdata", {13'h0, ReadDataW},  32'd0);
    check("to_rdw",   {27'h0, RDW},        32'd12);
    check("to_rsrc",  {31'h0, ResultSrcW}, 32'd1);
    check("to_state_idle", {30'h0, state_dbg}, 32'd0);
    idle_inputs();
    step();
    check("to_err_sticky", {31'h0, mem_err}, 32'd1);

    // Reset in the middle of a word load, during byte 1
    exp_q.push_back({1'b0, 19'h00300, 8'h00});
    drive_op(1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 19'h0, 19'h00300);
    mem_ack = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    check("rmid_addr_idx1", {13'h0, mem_addr}, 32'h301);
    reset = 1'b1;
    step();
    check("rmid_req",   {31'h0, mem_req},    32'd0);
    check("rmid_stall", {31'h0, StallM},     32'd0);
    check("rmid_state", {30'h0, state_dbg},  32'd0);
    check("rmid_regw",  {31'h0, RegWriteW},  32'd0);
    check("rmid_rsrc",  {31'h0, ResultSrcW}, 32'd0);
    check("rmid_rdw",   {27'h0, RDW},        32'd0);
    check("rmid_alu_w", {13'h0, ALUResultW}, 32'd0);
    check("rmid_rdata", {13'h0, ReadDataW},  32'd0);
    check("rmid_err",   {31'h0, mem_err},    32'd0);
    reset = 1'b0;
    idle_inputs();
    step();

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
